// File: rtl/datamem_pkg.sv
// Shared definitions for the data-memory family: byte width and the byte-enable merge.
package datamem_pkg;

    localparam int BYTE_W   = 8;
    localparam int MERGE_W  = 256;
    localparam int MERGE_BE = MERGE_W / BYTE_W;

    // Wide enough for any word this family uses; callers zero-extend in and truncate out.
    function automatic logic [MERGE_W-1:0] be_merge(
        input logic [MERGE_W-1:0]  old_word,
        input logic [MERGE_W-1:0]  new_word,
        input logic [MERGE_BE-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MERGE_BE; i++) begin
            if (be[i]) res[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
        end
        return res;
    endfunction

endpackage

// File: rtl/datamem_bank.sv
// DEPTH x DATA_W storage with one synchronous read and one synchronous write port.
// A read and write to the same index in one cycle returns the old word.
module datamem_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
        if (we) mem[waddr] <= wdata;
    end

endmodule

// File: rtl/datamem_rmw.sv
// Data memory with byte-enabled read-modify-write, newest-data forwarding,
// handshaked 1-cycle reads and out-of-range address flagging.
module datamem_rmw
    import datamem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/BYTE_W-1:0] wr_be,
    input  logic                     rd_en,
    output logic                     rd_ready,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     addr_err
);

    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int IDX_W  = $clog2(DEPTH);

    logic              rd_acc, wr_oor, rd_oor, s2_hit;
    logic [IDX_W-1:0]  wr_idx, rd_idx, acc_idx;
    logic [DATA_W-1:0] bank_q, old_p1, merged_p1, rd_word, rd_hold;

    logic              vld_p1, rd_vld_p1, rd_oor_p1, fwd_p1;
    logic [IDX_W-1:0]  idx_p1;
    logic [DATA_W-1:0] data_p1, fwd_word_p1;
    logic [NBYTES-1:0] be_p1;

    // Accept stage (S1): writes win the single array read port over reads.
    assign rd_ready = ~wr_en;
    assign rd_acc   = rd_en & ~wr_en;
    assign wr_idx   = wr_addr[IDX_W-1:0];
    assign rd_idx   = rd_addr[IDX_W-1:0];
    assign wr_oor   = (wr_addr >> IDX_W) != '0;
    assign rd_oor   = (rd_addr >> IDX_W) != '0;
    assign acc_idx  = wr_en ? wr_idx : rd_idx;
    // The array returns pre-write data, so an S2 write to the same index must be forwarded.
    assign s2_hit   = vld_p1 && (idx_p1 == acc_idx);

    // Merge stage (S2): old word comes from the forward latch or the array.
    assign old_p1    = fwd_p1 ? fwd_word_p1 : bank_q;
    assign merged_p1 = DATA_W'(be_merge(MERGE_W'(old_p1), MERGE_W'(data_p1), MERGE_BE'(be_p1)));
    assign rd_word   = rd_oor_p1 ? '0 : old_p1;
    assign rd_valid  = rd_vld_p1;
    assign rd_data   = rd_vld_p1 ? rd_word : rd_hold;

    datamem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk   (clk),
        .re    (wr_en | rd_acc),
        .raddr (acc_idx),
        .rdata (bank_q),
        .we    (vld_p1 & rst_n),
        .waddr (idx_p1),
        .wdata (merged_p1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            rd_vld_p1 <= 1'b0;
            addr_err  <= 1'b0;
            rd_hold   <= '0;
        end else begin
            vld_p1    <= wr_en & ~wr_oor;
            rd_vld_p1 <= rd_acc;
            addr_err  <= wr_en ? wr_oor : (rd_acc & rd_oor);
            if (rd_vld_p1) rd_hold <= rd_word;
        end
        idx_p1      <= wr_idx;
        data_p1     <= wr_data;
        be_p1       <= wr_be;
        fwd_p1      <= s2_hit;
        fwd_word_p1 <= merged_p1;
        rd_oor_p1   <= rd_oor;
    end

endmodule

// File: tb/tb_datamem_rmw.sv
// Bench for datamem_rmw: reference word model plus a queue of expected read results.
module tb_datamem_rmw;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 15;
    localparam int DEPTH  = 64;
    localparam int IDX_W  = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [3:0]        wr_be = '0;
    logic              rd_en = 1'b0;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              addr_err;

    int n_cmp = 0;
    int n_fail = 0;
    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] exp_v;

    datamem_rmw #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_en    (rd_en),
        .rd_ready (rd_ready),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every rd_valid beat must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: rd_valid=1 rd_data=%h, expected no read outstanding", rd_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (rd_data !== exp_v) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h expected %h", rd_data, exp_v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input logic [3:0] be, input bit commit);
        logic exp_e;
        exp_e = (a >= ADDR_W'(DEPTH));
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        if (commit && !exp_e) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) model[a[IDX_W-1:0]][8*i +: 8] = d[8*i +: 8];
        end
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if (addr_err !== exp_e) begin
            n_fail++;
            $display("FAIL addr_err_wr: addr=%0d got %b expected %b", a, addr_err, exp_e);
        end
    endtask

    task automatic drive_read(input logic [ADDR_W-1:0] a);
        logic exp_e;
        exp_e = (a >= ADDR_W'(DEPTH));
        rd_en = 1'b1; rd_addr = a;
        #1;
        for (int k = 0; k < 8 && rd_ready !== 1'b1; k++) tick();
        n_cmp++;
        if (rd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_ready_timeout: rd_ready=%b expected 1", rd_ready);
        end else begin
            exp_q.push_back(exp_e ? '0 : model[a[IDX_W-1:0]]);
        end
        tick();
        rd_en = 1'b0;
        n_cmp++;
        if (addr_err !== exp_e) begin
            n_fail++;
            $display("FAIL addr_err_rd: addr=%0d got %b expected %b", a, addr_err, exp_e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_cmp += 3;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        drive_write(5, 32'hDEADBEEF, 4'hF, 1);
        drive_read(5);
        tick(); tick();
        drive_read(5);
        // Write to one index in S2 while a read of another index is accepted.
        drive_write(30, 32'h30303030, 4'hF, 1);
        drive_read(5);
        tick(); tick();
        drive_read(30);
    endtask

    task automatic test_byte_merge();
        drive_write(3, 32'h11223344, 4'hF, 1);
        drive_write(3, 32'hAABBCCDD, 4'b0101, 1);
        drive_read(3);
        tick(); tick();
        n_cmp += 2;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL hold_rd_valid: got %b expected 0", rd_valid); end
        if (rd_data !== 32'h11BB33DD) begin n_fail++; $display("FAIL hold_rd_data: got %h expected 11bb33dd", rd_data); end
    endtask

    task automatic test_back_to_back();
        drive_write(7, 32'h0, 4'hF, 1);
        tick(); tick();
        drive_write(7, 32'h000000AA, 4'b0001, 1);
        drive_write(7, 32'hBB000000, 4'b1000, 1);
        drive_read(7);
        drive_write(7, 32'hFFFFFFFF, 4'b0000, 1);
        drive_write(7, 32'h00CC0000, 4'b0100, 1);
        drive_write(7, 32'h0000DD00, 4'b0010, 1);
        drive_read(7);
        tick(); tick();
        drive_read(7);
    endtask

    task automatic test_forward_priority();
        drive_write(9, 32'hCAFEF00D, 4'hF, 1);
        drive_read(9);
        wr_en = 1'b1; wr_addr = 20; wr_data = 32'h12345678; wr_be = 4'hF;
        model[20] = 32'h12345678;
        rd_en = 1'b1; rd_addr = 9;
        #1;
        n_cmp++;
        if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_blocked: got %b expected 0", rd_ready); end
        tick();
        wr_en = 1'b0;
        #1;
        n_cmp++;
        if (rd_ready !== 1'b1) begin
            n_fail++; $display("FAIL rd_ready_release: got %b expected 1", rd_ready);
        end else begin
            exp_q.push_back(model[9]);
        end
        tick();
        rd_en = 1'b0;
        n_cmp++;
        if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid_after_wait: got %b expected 1", rd_valid); end
        drive_read(20);
    endtask

    task automatic test_range();
        drive_write(0, 32'h0BADC0DE, 4'hF, 1);
        tick(); tick();
        drive_write(64, 32'hFFFFFFFF, 4'hF, 1);
        tick();
        n_cmp++;
        if (addr_err !== 1'b0) begin n_fail++; $display("FAIL addr_err_pulse: got %b expected 0", addr_err); end
        drive_read(0);
        drive_write(15'h4005, 32'h0, 4'hF, 1);
        tick(); tick();
        drive_read(5);
        drive_read(100);
        tick();
    endtask

    task automatic test_reset_mid();
        drive_write(12, 32'h55AA55AA, 4'hF, 1);
        tick(); tick();
        drive_read(12);
        drive_write(12, 32'h12121212, 4'hF, 0);
        rst_n = 1'b0;
        tick();
        n_cmp += 3;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_rd_valid: got %b expected 0", rd_valid); end
        if (rd_data !== '0) begin n_fail++; $display("FAIL midreset_rd_data: got %h expected 0", rd_data); end
        if (addr_err !== 1'b0) begin n_fail++; $display("FAIL midreset_addr_err: got %b expected 0", addr_err); end
        rst_n = 1'b1;
        tick(); tick();
        drive_read(12);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_merge();
        test_back_to_back();
        test_forward_priority();
        test_range();
        test_reset_mid();
        tick(); tick(); tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reads_outstanding: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
